div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port div_req_i, input, 1, the instruction in EX is DIV/DIVU.
REQ-004 SHALL have port signed_i, input, 1, 1 = DIV (signed), 0 = DIVU.
REQ-005 SHALL have ports reg1_i and reg2_i, input, 32 each, dividend and divisor from ID/EX.
REQ-006 SHALL have port flush_i, input, 1, pipeline flush/exception; cancels the divide in flight.
REQ-007 SHALL have port div_result_i, input, 64, divider result: [63:32] remainder, [31:0] quotient.
REQ-008 SHALL have port div_ready_i, input, 1, divider result valid.
REQ-009 SHALL have port div_start_o, output, 1, registered start to divider: 1 = start, 0 = stop.
REQ-010 SHALL have port div_annul_o, output, 1, combinational cancel to divider.
REQ-011 SHALL have ports signed_div_o (output, 1), div_opdata1_o (output, 32) and div_opdata2_o (output, 32), registered operands and signedness to divider.
REQ-012 SHALL have port stallreq_o, output, 1, combinational pipeline stall request.
REQ-013 SHALL have port whilo_o, output, 1, HI/LO write enable.
REQ-014 SHALL have ports hi_o and lo_o, output, 32 each, remainder and quotient for HI/LO.
REQ-015 SHALL have port timeout_o, output, 1, sticky watchdog error flag.

Function
REQ-016 SHALL implement three states: IDLE, WAIT, DONE.
REQ-017 IDLE with div_req_i=1 and flush_i=0 SHALL assert stallreq_o combinationally in that same cycle.
REQ-018 In that same IDLE condition, at the clock edge the block SHALL:
- latch reg1_i, reg2_i and signed_i into the operand outputs;
- set div_start_o=1;
- clear the watchdog counter;
- go to WAIT.
REQ-019 IDLE with div_req_i=0, or with flush_i=1, SHALL stay in IDLE with stallreq_o=0 and div_start_o=0.
REQ-020 In WAIT, div_opdata1_o, div_opdata2_o and signed_div_o SHALL stay unchanged; the divider samples them again at completion for sign correction.
REQ-021 In WAIT, stallreq_o SHALL be 1, except in a cycle where flush_i=1 or the watchdog fires.
REQ-022 WAIT with div_ready_i=1 and flush_i=0 SHALL, at the edge:
- capture hi_o <= div_result_i[63:32] and lo_o <= div_result_i[31:0];
- set whilo_o=1;
- set div_start_o=0, which is the stop indication that returns the divider to idle;
- go to DONE.
REQ-023 WAIT with flush_i=1 SHALL:
- drive div_annul_o=1 combinationally in that cycle;
- at the edge, set div_start_o=0, leave whilo_o=0 and go to IDLE.
- flush_i SHALL take priority over a simultaneous div_ready_i.
REQ-024 The watchdog SHALL be a 6-bit counter that increments each WAIT cycle.
REQ-025 When the watchdog reaches 48 in WAIT without ready or flush, the block SHALL:
- assert div_annul_o for that cycle;
- set timeout_o=1, held until reset;
- set div_start_o=0;
- go to IDLE without writing HI/LO.
REQ-026 DONE SHALL last exactly one cycle, with stallreq_o=0 and whilo_o=1; hi_o and lo_o SHALL be valid during it.
REQ-027 At the edge ending DONE, the block SHALL clear whilo_o and go to IDLE; whilo_o SHALL therefore be exactly a one-cycle pulse.
REQ-028 div_req_i SHALL be ignored in DONE; the instruction leaves EX at the end of DONE.
REQ-029 hi_o and lo_o SHALL hold their last captured value until the next capture.
REQ-030 A divisor of 0 SHALL need no special handling; the divider's ready with an all-zero result SHALL be passed through as a normal completion.
REQ-031 div_annul_o SHALL be 0 in IDLE and DONE.

Reset
REQ-032 While rst=0, the block SHALL immediately, without waiting for clk:
- enter IDLE;
- drive div_start_o, whilo_o, timeout_o and the watchdog counter to 0;
- drive signed_div_o, div_opdata1_o, div_opdata2_o, hi_o and lo_o to 0.
REQ-033 While rst=0, the combinational outputs stallreq_o and div_annul_o SHALL be 0.
REQ-034 Reset asserted in any state, including mid-WAIT, SHALL abandon the operation with no HI/LO write.

Verification
REQ-035 The bench SHALL cover these directed scenarios against a divider model:
- DIVU 100/7 -> whilo_o pulses one cycle, hi_o=0x00000002, lo_o=0x0000000E; stallreq_o high from the request cycle to the cycle before DONE.
- DIV 0xFFFFFFF9 / 0x00000002 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD; div_opdata1_o stable throughout WAIT.
- DIVU 5/0 -> divider ready after about 3 cycles; hi_o=lo_o=0, single whilo_o pulse, timeout_o stays 0.
- flush_i=1 on the 10th WAIT cycle -> div_annul_o=1 for that cycle only; div_start_o=0 next cycle; no whilo_o; stallreq_o=0 in the flush cycle.
- div_ready_i held 0 -> at watchdog count 48: div_annul_o pulse, timeout_o=1 (sticky), IDLE, no whilo_o.
- rst=0 mid-WAIT -> div_start_o=0 and stallreq_o=0 immediately, without waiting for clk; after release, a new DIVU 9/3 gives lo_o=3, hi_o=0.

Source files
------------

// File: rtl/div_ctrl_if.sv
// Handshake bundle between the EX-stage divide controller (master) and the
// pipeline/divider environment (slave).
interface div_ctrl_if;
  logic        div_req_i;
  logic        signed_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic        flush_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        signed_div_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        stallreq_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        timeout_o;

  modport master (
    input  div_req_i, signed_i, reg1_i, reg2_i, flush_i, div_result_i, div_ready_i,
    output div_start_o, div_annul_o, signed_div_o, div_opdata1_o, div_opdata2_o,
           stallreq_o, whilo_o, hi_o, lo_o, timeout_o
  );

  modport slave (
    output div_req_i, signed_i, reg1_i, reg2_i, flush_i, div_result_i, div_ready_i,
    input  div_start_o, div_annul_o, signed_div_o, div_opdata1_o, div_opdata2_o,
           stallreq_o, whilo_o, hi_o, lo_o, timeout_o
  );
endinterface

// File: rtl/div_ctrl.sv
// EX-stage divide sequencer: starts the divider one edge after the request, stalls the pipe
// until ready, then writes HI/LO in a one-cycle DONE; flush or a 48-cycle watchdog cancels.
module div_ctrl (
  input  logic      clk,
  input  logic      rst,
  div_ctrl_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [5:0] WD_LIMIT = 6'd48;

  logic [1:0]  state_q, state_d;
  logic        start_q, start_d;
  logic        whilo_q, whilo_d;
  logic        timeout_q, timeout_d;
  logic [5:0]  wd_q, wd_d;
  logic        sgn_q, sgn_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic go;
  logic wd_fire;

  // The watchdog holds the count of WAIT cycles already spent; it fires in the cycle it reads 48.
  assign go      = (state_q == ST_IDLE) && bus.div_req_i && !bus.flush_i;
  assign wd_fire = (state_q == ST_WAIT) && !bus.flush_i && !bus.div_ready_i && (wd_q == WD_LIMIT);

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    whilo_d   = whilo_q;
    timeout_d = timeout_q;
    wd_d      = wd_q;
    sgn_d     = sgn_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          op1_d   = bus.reg1_i;
          op2_d   = bus.reg2_i;
          sgn_d   = bus.signed_i;
          start_d = 1'b1;
          wd_d    = 6'd0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.flush_i) begin
          start_d = 1'b0;
          state_d = ST_IDLE;
        end else if (bus.div_ready_i) begin
          hi_d    = bus.div_result_i[63:32];
          lo_d    = bus.div_result_i[31:0];
          whilo_d = 1'b1;
          start_d = 1'b0;
          state_d = ST_DONE;
        end else if (wd_q == WD_LIMIT) begin
          timeout_d = 1'b1;
          start_d   = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          wd_d = wd_q + 6'd1;
        end
      end
      ST_DONE: begin
        whilo_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        start_d = 1'b0;
        whilo_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      whilo_q   <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= 6'd0;
      sgn_q     <= 1'b0;
      op1_q     <= 32'd0;
      op2_q     <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      whilo_q   <= whilo_d;
      timeout_q <= timeout_d;
      wd_q      <= wd_d;
      sgn_q     <= sgn_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Reset gates the combinational outputs so a request held during reset cannot stall the pipe.
  assign bus.stallreq_o  = rst && (go || ((state_q == ST_WAIT) && !bus.flush_i && !wd_fire));
  assign bus.div_annul_o = rst && (state_q == ST_WAIT) && (bus.flush_i || wd_fire);

  assign bus.div_start_o   = start_q;
  assign bus.whilo_o       = whilo_q;
  assign bus.timeout_o     = timeout_q;
  assign bus.signed_div_o  = sgn_q;
  assign bus.div_opdata1_o = op1_q;
  assign bus.div_opdata2_o = op2_q;
  assign bus.hi_o          = hi_q;
  assign bus.lo_o          = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: divider responder, transaction-level expectation model and directed scenarios.
module tb_div_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_ctrl_if bus ();

  div_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  // Divider stand-in: ready pulses in the dv_lat-th cycle that start is seen high (0 = never).
  int dv_lat = 0;
  int dv_cnt = 0;
  bit dv_active = 1'b0;
  initial begin
    bus.div_ready_i  = 1'b0;
    bus.div_result_i = 64'd0;
  end
  always @(posedge clk) begin
    #1;
    bus.div_ready_i = 1'b0;
    if (!rst || !bus.div_start_o) begin
      dv_active = 1'b0;
    end else begin
      if (!dv_active) begin
        dv_active = 1'b1;
        dv_cnt    = 0;
      end
      dv_cnt++;
      if (dv_lat != 0 && dv_cnt == dv_lat) begin
        bus.div_ready_i  = 1'b1;
        bus.div_result_i = ref_div(bus.signed_div_o, bus.div_opdata1_o, bus.div_opdata2_o);
      end
    end
  end

  // Transaction model: a divide is "busy" from acceptance until it completes, is flushed or times out.
  bit          m_busy, m_done, m_start, m_timeout, m_sgn;
  int          m_waited;
  logic [31:0] m_op1, m_op2, m_hi, m_lo;
  int          n_whilo = 0, n_annul = 0, n_stall = 0;

  always @(negedge clk) begin
    bit idle, wd, e_stall, e_annul;
    if (!rst) begin
      m_busy = 0; m_done = 0; m_start = 0; m_timeout = 0; m_sgn = 0; m_waited = 0;
      m_op1 = 0; m_op2 = 0; m_hi = 0; m_lo = 0;
      e_stall = 0;
      e_annul = 0;
      idle    = 1;
      wd      = 0;
    end else begin
      idle    = !m_busy && !m_done;
      wd      = m_busy && !bus.flush_i && !bus.div_ready_i && (m_waited == 48);
      e_stall = (idle && bus.div_req_i && !bus.flush_i) || (m_busy && !bus.flush_i && !wd);
      e_annul = m_busy && (bus.flush_i || wd);
    end
    chk("start",   bus.div_start_o,   m_start);
    chk("whilo",   bus.whilo_o,       m_done);
    chk("stall",   bus.stallreq_o,    e_stall);
    chk("annul",   bus.div_annul_o,   e_annul);
    chk("timeout", bus.timeout_o,     m_timeout);
    chk("hi",      bus.hi_o,          m_hi);
    chk("lo",      bus.lo_o,          m_lo);
    chk("op1",     bus.div_opdata1_o, m_op1);
    chk("op2",     bus.div_opdata2_o, m_op2);
    chk("sgn",     bus.signed_div_o,  m_sgn);
    if (bus.whilo_o)     n_whilo++;
    if (bus.div_annul_o) n_annul++;
    if (bus.stallreq_o)  n_stall++;
    if (rst) begin
      if (m_done) begin
        m_done = 0;
      end else if (idle && bus.div_req_i && !bus.flush_i) begin
        m_busy = 1; m_start = 1; m_waited = 0;
        m_op1 = bus.reg1_i; m_op2 = bus.reg2_i; m_sgn = bus.signed_i;
      end else if (m_busy) begin
        if (bus.flush_i) begin
          m_busy = 0; m_start = 0;
        end else if (bus.div_ready_i) begin
          m_busy = 0; m_start = 0; m_done = 1;
          m_hi = bus.div_result_i[63:32];
          m_lo = bus.div_result_i[31:0];
        end else if (wd) begin
          m_busy = 0; m_start = 0; m_timeout = 1;
        end else begin
          m_waited++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until the operation ends; flush_at>0 flushes on that WAIT cycle.
  task automatic run_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int flush_at, input int budget);
    bit fin;
    fin = 0;
    dv_lat = lat;
    bus.signed_i = sg; bus.reg1_i = a; bus.reg2_i = b;
    bus.div_req_i = 1'b1; bus.flush_i = 1'b0;
    for (int k = 0; k < budget && !fin; k++) begin
      step();
      if (!m_busy && !m_done) fin = 1;
      else bus.flush_i = (flush_at > 0) && m_busy && (m_waited == flush_at - 1);
    end
    bus.div_req_i = 1'b0;
    bus.flush_i   = 1'b0;
    chk("op_done", fin, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int s_wh, s_an, s_st;
    rst = 1'b0;
    bus.div_req_i = 1'b0; bus.signed_i = 1'b0; bus.flush_i = 1'b0;
    bus.reg1_i = 32'd0; bus.reg2_i = 32'd0;
    repeat (3) step();
    chk("rst_start",   bus.div_start_o, 1'b0);
    chk("rst_timeout", bus.timeout_o,   1'b0);
    chk("rst_hi",      bus.hi_o,        32'd0);
    rst = 1'b1;
    step();

    // DIVU 100/7
    s_wh = n_whilo; s_st = n_stall;
    run_div(1'b0, 32'd100, 32'd7, 5, 0, 40);
    chk("divu_hi",     bus.hi_o, 32'h0000_0002);
    chk("divu_lo",     bus.lo_o, 32'h0000_000E);
    chk("divu_whilo",  n_whilo - s_wh, 1);
    chk("divu_stall",  n_stall - s_st, 6);
    step();

    // DIVU 5/0
    s_wh = n_whilo; s_st = n_stall;
    run_div(1'b0, 32'd5, 32'd0, 3, 0, 40);
    chk("dz_hi",      bus.hi_o, 32'd0);
    chk("dz_lo",      bus.lo_o, 32'd0);
    chk("dz_whilo",   n_whilo - s_wh, 1);
    chk("dz_stall",   n_stall - s_st, 4);
    chk("dz_timeout", bus.timeout_o, 1'b0);
    step();

    // DIV -7/2
    s_wh = n_whilo;
    run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 4, 0, 40);
    chk("div_hi",    bus.hi_o, 32'hFFFF_FFFF);
    chk("div_lo",    bus.lo_o, 32'hFFFF_FFFD);
    chk("div_op1",   bus.div_opdata1_o, 32'hFFFF_FFF9);
    chk("div_whilo", n_whilo - s_wh, 1);
    step();

    // Flush on the 10th WAIT cycle of a long divide
    s_wh = n_whilo; s_an = n_annul; s_st = n_stall;
    run_div(1'b0, 32'd1000, 32'd3, 20, 10, 40);
    chk("fl_start", bus.div_start_o, 1'b0);
    chk("fl_annul", n_annul - s_an, 1);
    chk("fl_whilo", n_whilo - s_wh, 0);
    chk("fl_stall", n_stall - s_st, 10);
    chk("fl_hi_hold", bus.hi_o, 32'hFFFF_FFFF);
    repeat (3) step();

    // Divider never answers: watchdog
    s_wh = n_whilo; s_an = n_annul; s_st = n_stall;
    run_div(1'b0, 32'd77, 32'd5, 0, 0, 80);
    chk("wd_timeout", bus.timeout_o, 1'b1);
    chk("wd_annul",   n_annul - s_an, 1);
    chk("wd_whilo",   n_whilo - s_wh, 0);
    chk("wd_stall",   n_stall - s_st, 49);
    repeat (3) step();
    chk("wd_sticky",  bus.timeout_o, 1'b1);

    // Asynchronous reset mid-WAIT, request still asserted
    dv_lat = 0;
    bus.signed_i = 1'b0; bus.reg1_i = 32'd20; bus.reg2_i = 32'd3; bus.div_req_i = 1'b1;
    repeat (5) step();
    #2 rst = 1'b0;
    #1;
    chk("arst_start", bus.div_start_o, 1'b0);
    chk("arst_stall", bus.stallreq_o,  1'b0);
    chk("arst_annul", bus.div_annul_o, 1'b0);
    bus.div_req_i = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    chk("arst_hi",      bus.hi_o,      32'd0);
    chk("arst_timeout", bus.timeout_o, 1'b0);
    step();

    s_wh = n_whilo;
    run_div(1'b0, 32'd9, 32'd3, 2, 0, 40);
    chk("post_lo",    bus.lo_o, 32'd3);
    chk("post_hi",    bus.hi_o, 32'd0);
    chk("post_whilo", n_whilo - s_wh, 1);
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
